// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer: pixel stage that draws a 10x20 Tetris board, its border and black background.
// Ports: clk/reset (async, active-high); video_on, hsync_in, vsync_in, x, y from the VGA timing generator;
//   wr_en/wr_col/wr_row/wr_color cell write port; clr starts a full-board clear while busy is high;
//   rgb {R,G,B} nibbles, hsync, vsync and frame_tick, all delayed 3 cycles from the inputs.
// Optional TETRIS_GRID_EN draws 12'h333 grid lines on the top/left pixels of empty cells.
module tetris_board_renderer #(
  parameter int X0 = 240,
  parameter int Y0 = 80,
  parameter int CELL_LOG2 = 4,
  parameter int BORDER = 4,
  parameter int CLR_CELLS = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        wr_en,
  input  logic [3:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [2:0]  wr_color,
  input  logic        clr,
  output logic        busy,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);
  localparam logic [10:0] BX0 = 11'(X0);
  localparam logic [10:0] BX1 = 11'(X0 + (10 << CELL_LOG2));
  localparam logic [10:0] BY0 = 11'(Y0);
  localparam logic [10:0] BY1 = 11'(Y0 + (20 << CELL_LOG2));
  localparam logic [10:0] GX0 = 11'(X0 - BORDER);
  localparam logic [10:0] GX1 = 11'(X0 + (10 << CELL_LOG2) + BORDER);
  localparam logic [10:0] GY0 = 11'(Y0 - BORDER);
  localparam logic [10:0] GY1 = 11'(Y0 + (20 << CELL_LOG2) + BORDER);
  localparam logic [7:0]  LAST = 8'(CLR_CELLS - 1);
  localparam logic [11:0] PAL [8] = '{12'h111, 12'h0FF, 12'hFF0, 12'hA0F,
                                      12'h0F0, 12'hF00, 12'h00F, 12'hF80};

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t     state, state_n;
  logic [7:0] clr_addr, clr_addr_n;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_n;
      clr_addr <= clr_addr_n;
    end

  always_comb begin
    state_n    = clr ? CLEAR : (state == CLEAR && clr_addr == LAST) ? IDLE : state;
    clr_addr_n = clr ? '0 : state == CLEAR ? clr_addr + 8'd1 : clr_addr;
  end

  assign busy = state == CLEAR;

  // Port B: clearing owns the write port; game writes are only taken when idle and in range.
  logic [7:0] wr_addr, pb_addr, rd_addr;
  logic       wr_ok, pb_we;
  logic [2:0] pb_data, rd_data;
  logic [2:0] mem [CLR_CELLS];

  assign wr_addr = {3'b0, wr_row} * 8'd10 + {4'b0, wr_col};
  assign wr_ok   = wr_en && !busy && wr_col < 4'd10 && wr_row < 5'd20;
  assign pb_we   = busy || wr_ok;
  assign pb_addr = busy ? clr_addr : wr_addr;
  assign pb_data = busy ? 3'd0 : wr_color;

  // Read-first: a same-address write in this cycle is seen by the next read.
  always_ff @(posedge clk) begin
    if (pb_we) mem[pb_addr] <= pb_data;
    rd_data <= mem[rd_addr];
  end

  logic [10:0] xe, ye, dx, dy;
  logic        board_c, grown_c;
  assign xe      = {1'b0, x};
  assign ye      = {1'b0, y};
  assign dx      = xe - BX0;
  assign dy      = ye - BY0;
  assign board_c = xe >= BX0 && xe < BX1 && ye >= BY0 && ye < BY1;
  assign grown_c = xe >= GX0 && xe < GX1 && ye >= GY0 && ye < GY1;

  logic       s1_board, s1_border, s1_von, s1_hs, s1_vs, s1_sof;
  logic [3:0] s1_col;
  logic [4:0] s1_row;
  logic       s2_board, s2_border, s2_von, s2_hs, s2_vs, s2_sof;

  // Out-of-board pixels read cell 0 so the RAM index always stays in range.
  assign rd_addr = s1_board ? {3'b0, s1_row} * 8'd10 + {4'b0, s1_col} : '0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {s1_board, s1_border, s1_von, s1_hs, s1_vs, s1_sof} <= '0;
      {s2_board, s2_border, s2_von, s2_hs, s2_vs, s2_sof} <= '0;
      s1_col <= '0;
      s1_row <= '0;
    end else begin
      s1_board  <= board_c;
      s1_border <= grown_c && !board_c;
      s1_col    <= 4'(dx >> CELL_LOG2);
      s1_row    <= 5'(dy >> CELL_LOG2);
      s1_von    <= video_on;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s1_sof    <= x == 10'd0 && y == 10'd0;
      {s2_board, s2_border, s2_von, s2_hs, s2_vs, s2_sof} <=
        {s1_board, s1_border, s1_von, s1_hs, s1_vs, s1_sof};
    end

  logic [11:0] cell_rgb;
`ifdef TETRIS_GRID_EN
  logic s1_gx, s1_gy, s2_gx, s2_gy;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {s1_gx, s1_gy, s2_gx, s2_gy} <= '0;
    end else begin
      s1_gx <= dx[CELL_LOG2-1:0] == '0;
      s1_gy <= dy[CELL_LOG2-1:0] == '0;
      s2_gx <= s1_gx;
      s2_gy <= s1_gy;
    end
  assign cell_rgb = (rd_data == 3'd0 && (s2_gx || s2_gy)) ? 12'h333 : PAL[rd_data];
`else
  assign cell_rgb = PAL[rd_data];
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rgb        <= '0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      rgb        <= !s2_von ? 12'h000 : s2_board ? cell_rgb : s2_border ? 12'hCCC : 12'h000;
      hsync      <= s2_hs;
      vsync      <= s2_vs;
      frame_tick <= s2_sof;
    end
endmodule

// File: tb/tb_tetris_board_renderer.sv
// tb_tetris_board_renderer: table-driven pixel checks through a 3-cycle scoreboard plus clear/reset sequences.
module tb_tetris_board_renderer;
  logic        clk = 0, reset = 1, video_on = 0, hsync_in = 0, vsync_in = 0;
  logic        wr_en = 0, clr = 0;
  logic [9:0]  x = 0, y = 0;
  logic [3:0]  wr_col = 0;
  logic [4:0]  wr_row = 0;
  logic [2:0]  wr_color = 0;
  logic        busy, hsync, vsync, frame_tick;
  logic [11:0] rgb;

`ifdef TETRIS_GRID_EN
  localparam logic [11:0] GE0 = 12'h333;
`else
  localparam logic [11:0] GE0 = 12'h111;
`endif

  tetris_board_renderer dut (
    .clk(clk), .reset(reset), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_color(wr_color),
    .clr(clr), .busy(busy), .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {logic chk; logic sy; logic [11:0] rgb; logic hs; logic vs; logic ft; int id;} exp_t;
  typedef struct {logic [9:0] x; logic [9:0] y; logic von; logic [11:0] rgb;} vec_t;

  exp_t q[$];
  vec_t tbl[17];
  int   total = 0, passed = 0;
  logic sync_en = 0;

  task automatic check(input string n, input int id, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s[%0d]: got %0h want %0h", n, id, got, want);
  endtask

  task automatic drive(input logic [9:0] px, input logic [9:0] py, input logic von,
                       input logic c, input logic [11:0] e, input int id);
    exp_t r;
    @(negedge clk);
    x = px; y = py; video_on = von; wr_en = 0; clr = 0;
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
    r.chk = c; r.sy = sync_en; r.rgb = e; r.hs = hsync_in; r.vs = vsync_in;
    r.ft = px == 10'd0 && py == 10'd0; r.id = id;
    q.push_back(r);
  endtask

  task automatic idle();
    drive(10'd700, 10'd500, 1'b0, 1'b0, 12'h000, -1);
  endtask

  task automatic wr(input logic [3:0] c, input logic [4:0] r, input logic [2:0] col);
    idle();
    wr_en = 1; wr_col = c; wr_row = r; wr_color = col;
  endtask

  task automatic pulse_clr();
    idle();
    clr = 1;
  endtask

  task automatic busy_len(input string n, input int want);
    int c = 0;
    do begin idle(); c++; end while (busy && c < 1000);
    check(n, 0, c, want);
  endtask

  always @(posedge clk) begin
    exp_t r;
    #1;
    if (q.size() >= 3) begin
      r = q.pop_front();
      if (r.chk) check("rgb", r.id, 32'(rgb), 32'(r.rgb));
      if (r.sy) begin
        check("hsync", r.id, 32'(hsync), 32'(r.hs));
        check("vsync", r.id, 32'(vsync), 32'(r.vs));
        check("frame_tick", r.id, 32'(frame_tick), 32'(r.ft));
      end
    end
  end

  initial begin
    tbl[0]  = '{10'd240, 10'd80,  1'b1, 12'hF00};
    tbl[1]  = '{10'd255, 10'd95,  1'b1, 12'hF00};
    tbl[2]  = '{10'd256, 10'd80,  1'b1, GE0};
    tbl[3]  = '{10'd239, 10'd80,  1'b1, 12'hCCC};
    tbl[4]  = '{10'd235, 10'd80,  1'b1, 12'h000};
    tbl[5]  = '{10'd236, 10'd80,  1'b1, 12'hCCC};
    tbl[6]  = '{10'd100, 10'd100, 1'b1, 12'h000};
    tbl[7]  = '{10'd240, 10'd80,  1'b0, 12'h000};
    tbl[8]  = '{10'd399, 10'd399, 1'b1, 12'hF80};
    tbl[9]  = '{10'd400, 10'd399, 1'b1, 12'hCCC};
    tbl[10] = '{10'd399, 10'd400, 1'b1, 12'hCCC};
    tbl[11] = '{10'd404, 10'd200, 1'b1, 12'h000};
    tbl[12] = '{10'd290, 10'd120, 1'b1, 12'hA0F};
    tbl[13] = '{10'd240, 10'd76,  1'b1, 12'hCCC};
    tbl[14] = '{10'd240, 10'd75,  1'b1, 12'h000};
    tbl[15] = '{10'd250, 10'd90,  1'b0, 12'h000};
    tbl[16] = '{10'd403, 10'd403, 1'b1, 12'hCCC};

    idle(); idle();
    #1;
    check("rst_rgb", 0, 32'(rgb), 32'h0);
    check("rst_hsync", 0, 32'(hsync), 32'h0);
    check("rst_vsync", 0, 32'(vsync), 32'h0);
    check("rst_frame_tick", 0, 32'(frame_tick), 32'h0);
    check("rst_busy", 0, 32'(busy), 32'h1);
    @(negedge clk);
    reset = 0;
    sync_en = 1;
    busy_len("busy_after_reset", 200);
    drive(10'd250, 10'd90, 1'b1, 1'b1, 12'h111, 100);

    wr(4'd0, 5'd0, 3'd5);
    wr(4'd9, 5'd19, 3'd7);
    wr(4'd3, 5'd2, 3'd3);
    for (int i = 0; i < 17; i++) drive(tbl[i].x, tbl[i].y, tbl[i].von, 1'b1, tbl[i].rgb, i);

    wr(4'd10, 5'd0, 3'd2);
    wr(4'd0, 5'd20, 3'd2);
    wr(4'd15, 5'd0, 3'd2);
    drive(10'd245, 10'd100, 1'b1, 1'b1, 12'h111, 200);
    drive(10'd330, 10'd100, 1'b1, 1'b1, 12'h111, 201);
    drive(10'd240, 10'd80,  1'b1, 1'b1, 12'hF00, 202);

    pulse_clr();
    repeat (30) idle();
    pulse_clr();
    busy_len("clr_restart", 201);
    pulse_clr();
    repeat (100) idle();
    wr(4'd5, 5'd5, 3'd4);
    busy_len("clr_tail", 100);
    drive(10'd330, 10'd170, 1'b1, 1'b1, 12'h111, 300);
    drive(10'd240, 10'd80,  1'b1, 1'b1, GE0, 301);
    drive(10'd399, 10'd399, 1'b1, 1'b1, 12'h111, 302);

    drive(10'd0, 10'd0, 1'b0, 1'b1, 12'h000, 400);
    drive(10'd1, 10'd0, 1'b0, 1'b1, 12'h000, 401);
    drive(10'd0, 10'd1, 1'b0, 1'b1, 12'h000, 402);
    drive(10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 403);
    repeat (20) idle();

    wr(4'd0, 5'd0, 3'd5);
    wr(4'd9, 5'd19, 3'd7);
    wr(4'd3, 5'd2, 3'd3);
    drive(10'd240, 10'd80, 1'b1, 1'b1, 12'hF00, 500);
    sync_en = 0;
    pulse_clr();
    repeat (51) idle();
    reset = 1;
    #1;
    check("mid_rst_rgb", 0, 32'(rgb), 32'h0);
    check("mid_rst_busy", 0, 32'(busy), 32'h1);
    idle(); idle();
    reset = 0;
    sync_en = 1;
    busy_len("busy_after_mid_reset", 200);
    drive(10'd240, 10'd80,  1'b1, 1'b1, GE0, 600);
    drive(10'd399, 10'd399, 1'b1, 1'b1, 12'h111, 601);
    drive(10'd290, 10'd120, 1'b1, 1'b1, 12'h111, 602);
    repeat (4) idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
